mem_access_way0: RTL

- Memory-access stage for way0, directly downstream of the way0 FU register buffer.
- Accepts one buffered FU operation per handshake. Loads and stores go to the data RAM through a req/dataOk handshake; every other op passes through.
- Produces the write-back packet (rd enable, address, data, pID) for the commit stage.
- Holds byte-lane alignment, load sign/zero extension, store strobe generation, misalignment detection and flush handling.

---
 rtl/mem_access_way0.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_way0.sv
// Way0 memory-access stage: issues loads/stores to the data RAM, passes other
// ops through, and builds the write-back packet for commit.
module mem_access_way0 #(
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        rdWriteEnable_i,
  input  logic [4:0]  rdAddr_i,
  input  logic [63:0] rdData_i,
  input  logic [1:0]  way0_pID_i,
  input  logic [6:0]  opCode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] readAddr_i,
  input  logic [31:0] writeAddr_i,
  input  logic [63:0] writeData_i,
  input  logic        jumpClear_i,
  output logic        ramReq_o,
  output logic        ramWe_o,
  output logic [31:0] ramAddr_o,
  output logic [63:0] ramWData_o,
  output logic [7:0]  ramStrb_o,
  input  logic [63:0] ramRData_i,
  input  logic        dataOk_i,
  output logic        wbValid_o,
  input  logic        wbReady_i,
  output logic        wbRdWriteEnable_o,
  output logic [4:0]  wbRdAddr_o,
  output logic [63:0] wbRdData_o,
  output logic [1:0]  wbPID_o,
  output logic        misalign_o
);

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_ram_req, w_ram_req;
  logic            r_ram_we, w_ram_we;
  logic [AW-1:0]   r_ram_addr, w_ram_addr;
  logic [DW-1:0]   r_ram_wdata, w_ram_wdata;
  logic [7:0]      r_ram_strb, w_ram_strb;
  logic            r_wb_valid, w_wb_valid;
  logic            r_wb_we, w_wb_we;
  logic [4:0]      r_wb_addr, w_wb_addr;
  logic [DW-1:0]   r_wb_data, w_wb_data;
  logic [1:0]      r_wb_pid, w_wb_pid;
  logic            r_misalign, w_misalign;
  logic            r_is_load, w_is_load_nxt;
  logic [2:0]      r_funct3, w_funct3_nxt;
  logic [2:0]      r_off, w_off_nxt;

  logic            w_is_load, w_is_store, w_is_mem, w_misal;
  logic [AW-1:0]   w_addr;
  logic [2:0]      w_off;
  logic [7:0]      w_strb_base, w_strb;
  logic [DW-1:0]   w_wdata, w_lane, w_load;

  // Request decode: access size comes from funct3[1:0], lane offset from addr[2:0]
  assign w_is_load  = (opCode_i == LOAD_OP);
  assign w_is_store = (opCode_i == STORE_OP);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_addr     = w_is_store ? writeAddr_i : readAddr_i;
  assign w_off      = w_addr[2:0];
  assign w_wdata    = writeData_i << {w_off, 3'b000};
  assign w_strb     = w_strb_base << w_off;

  always_comb begin
    w_strb_base = 8'h01;
    w_misal     = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin w_strb_base = 8'h01; w_misal = 1'b0;              end
      2'b01: begin w_strb_base = 8'h03; w_misal = w_off[0];          end
      2'b10: begin w_strb_base = 8'h0F; w_misal = |w_off[1:0];       end
      default: begin w_strb_base = 8'hFF; w_misal = |w_off;          end
    endcase
  end

  // Load lane extraction with sign/zero extension
  assign w_lane = ramRData_i >> {r_off, 3'b000};

  always_comb begin
    w_load = w_lane;
    case (r_funct3)
      3'b000:  w_load = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load = {56'd0, w_lane[7:0]};
      3'b101:  w_load = {48'd0, w_lane[15:0]};
      3'b110:  w_load = {32'd0, w_lane[31:0]};
      default: w_load = w_lane;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ram_req     = r_ram_req;
    w_ram_we      = r_ram_we;
    w_ram_addr    = r_ram_addr;
    w_ram_wdata   = r_ram_wdata;
    w_ram_strb    = r_ram_strb;
    w_wb_valid    = r_wb_valid;
    w_wb_we       = r_wb_we;
    w_wb_addr     = r_wb_addr;
    w_wb_data     = r_wb_data;
    w_wb_pid      = r_wb_pid;
    w_misalign    = r_misalign;
    w_is_load_nxt = r_is_load;
    w_funct3_nxt  = r_funct3;
    w_off_nxt     = r_off;
    case (r_state)
      IDLE: begin
        if (valid_i && !jumpClear_i) begin
          w_wb_addr  = rdAddr_i;
          w_wb_pid   = way0_pID_i;
          w_misalign = 1'b0;
          if (!w_is_mem) begin
            w_wb_we     = rdWriteEnable_i;
            w_wb_data   = rdData_i;
            w_wb_valid  = 1'b1;
            w_state_nxt = DONE;
          end else if (w_misal) begin
            w_wb_we     = 1'b0;
            w_wb_data   = '0;
            w_misalign  = 1'b1;
            w_wb_valid  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_ram_req     = 1'b1;
            w_ram_we      = w_is_store;
            w_ram_addr    = {w_addr[AW-1:3], 3'b000};
            w_ram_wdata   = w_wdata;
            w_ram_strb    = w_strb;
            w_wb_we       = w_is_load & rdWriteEnable_i;
            w_is_load_nxt = w_is_load;
            w_funct3_nxt  = funct3_i;
            w_off_nxt     = w_off;
            w_state_nxt   = WAIT;
          end
        end
      end
      WAIT: begin
        if (dataOk_i) begin
          w_ram_req = 1'b0;
          w_ram_we  = 1'b0;
          if (jumpClear_i) begin
            w_state_nxt = IDLE;
          end else begin
            w_wb_data   = r_is_load ? w_load : '0;
            w_wb_valid  = 1'b1;
            w_state_nxt = DONE;
          end
        end else if (jumpClear_i) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dataOk_i) begin
          w_ram_req   = 1'b0;
          w_ram_we    = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        if (wbReady_i || jumpClear_i) begin
          w_wb_valid  = 1'b0;
          w_misalign  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_strb  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_wb_pid    <= '0;
      r_misalign  <= 1'b0;
      r_is_load   <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ram_req   <= w_ram_req;
      r_ram_we    <= w_ram_we;
      r_ram_addr  <= w_ram_addr;
      r_ram_wdata <= w_ram_wdata;
      r_ram_strb  <= w_ram_strb;
      r_wb_valid  <= w_wb_valid;
      r_wb_we     <= w_wb_we;
      r_wb_addr   <= w_wb_addr;
      r_wb_data   <= w_wb_data;
      r_wb_pid    <= w_wb_pid;
      r_misalign  <= w_misalign;
      r_is_load   <= w_is_load_nxt;
      r_funct3    <= w_funct3_nxt;
      r_off       <= w_off_nxt;
    end
  end

  assign ready_o           = (r_state == IDLE);
  assign ramReq_o          = r_ram_req;
  assign ramWe_o           = r_ram_we;
  assign ramAddr_o         = r_ram_addr;
  assign ramWData_o        = r_ram_wdata;
  assign ramStrb_o         = r_ram_strb;
  assign wbValid_o         = r_wb_valid;
  assign wbRdWriteEnable_o = r_wb_we;
  assign wbRdAddr_o        = r_wb_addr;
  assign wbRdData_o        = r_wb_data;
  assign wbPID_o           = r_wb_pid;
  assign misalign_o        = r_misalign;

endmodule
